// File: rtl/mem_stall_ctrl_pkg.sv
// Shared types and constants for the data-cache stall controller.
package mem_ctrl_pkg;
  localparam int STATE_W = 3;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    CHECK     = 3'd2,
    HIT_WAIT  = 3'd3,
    MISS_WAIT = 3'd4,
    RELEASE   = 3'd5
  } state_t;

  function automatic logic isMemOp(input logic valid, input logic [5:0] op);
    return valid && (op == OP_LW || op == OP_SW);
  endfunction
endpackage

// File: rtl/mem_stall_ctrl_if.sv
// Pipeline/cache side signals of the stall controller; perf counters are
// always present and read as zero unless MEM_STALL_PERF_EN is defined.
interface mem_stall_ctrl_if;
  import mem_ctrl_pkg::*;

  logic [5:0]         op_d;
  logic               valid_d;
  logic               mult_busy;
  logic               cache_hit;
  logic               cache_busy;
  logic               stall_f;
  logic               stall_fd;
  logic               flush_de;
  logic               rf_wr_block;
  logic               mem_err;
  logic [STATE_W-1:0] state_o;
  logic [31:0]        hit_cnt;
  logic [31:0]        miss_cnt;
  logic [31:0]        stall_cycles;

  modport master (
    output op_d, valid_d, mult_busy, cache_hit, cache_busy,
    input  stall_f, stall_fd, flush_de, rf_wr_block, mem_err, state_o,
           hit_cnt, miss_cnt, stall_cycles
  );

  modport slave (
    input  op_d, valid_d, mult_busy, cache_hit, cache_busy,
    output stall_f, stall_fd, flush_de, rf_wr_block, mem_err, state_o,
           hit_cnt, miss_cnt, stall_cycles
  );
endinterface

// File: rtl/mem_stall_ctrl_timer.sv
// Loadable down-counter shared by the hit and miss wait states.
module stall_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      cnt <= '0;
    else if (load)     cnt <= loadVal;
    else if (dec)      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/mem_stall_ctrl.sv
// Data-cache stall/sequencing FSM for the 5-stage pipeline.
// Optional perf counters are built when MEM_STALL_PERF_EN is defined.
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int HIT_LAT      = 4,
  parameter int MISS_TIMEOUT = 31,
  parameter int CNT_W        = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_stall_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HIT_LAT - 1);
  localparam logic [CNT_W-1:0] MISS_LOAD = CNT_W'(MISS_TIMEOUT - 1);

  state_t           state, stateNext;
  logic             busyPrev, memErr, setErr, busyFall;
  logic             stall, rfBlock;
  logic             tLoad, tDec, tZero;
  logic [CNT_W-1:0] tLoadVal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busyPrev <= 1'b0;
      memErr   <= 1'b0;
    end else begin
      state    <= stateNext;
      busyPrev <= bus.cache_busy;
      if (setErr) memErr <= 1'b1;
    end
  end

  assign busyFall = busyPrev && !bus.cache_busy;

  always_comb begin
    stateNext = state;
    tLoad     = 1'b0;
    tLoadVal  = '0;
    tDec      = 1'b0;
    setErr    = 1'b0;
    stall     = 1'b0;
    rfBlock   = 1'b0;
    unique case (state)
      IDLE:
        if (isMemOp(bus.valid_d, bus.op_d) && !bus.mult_busy) stateNext = ISSUE;
      ISSUE: begin
        stall     = 1'b1;
        stateNext = CHECK;
      end
      CHECK: begin
        stall = 1'b1;
        tLoad = 1'b1;
        if (bus.cache_hit) begin
          tLoadVal  = HIT_LOAD;
          stateNext = HIT_WAIT;
        end else begin
          tLoadVal  = MISS_LOAD;
          stateNext = MISS_WAIT;
        end
      end
      HIT_WAIT: begin
        stall = 1'b1;
        if (tZero) stateNext = RELEASE;
        else       tDec      = 1'b1;
      end
      MISS_WAIT: begin
        stall   = 1'b1;
        rfBlock = 1'b1;
        // A fill completing on the timeout cycle still counts as success.
        if (busyFall) stateNext = RELEASE;
        else if (tZero) begin
          setErr    = 1'b1;
          stateNext = RELEASE;
        end else tDec = 1'b1;
      end
      // Decode is masked here so the just-unfrozen instruction is not re-issued.
      RELEASE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  stall_timer #(.CNT_W(CNT_W)) uTimer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tLoad),
    .loadVal (tLoadVal),
    .dec     (tDec),
    .zero    (tZero)
  );

  assign bus.stall_f     = stall | bus.mult_busy;
  assign bus.stall_fd    = stall;
  assign bus.flush_de    = stall;
  assign bus.rf_wr_block = rfBlock;
  assign bus.mem_err     = memErr;
  assign bus.state_o     = state;

`ifdef MEM_STALL_PERF_EN
  logic [31:0] hitCnt, missCnt, stallCyc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hitCnt   <= '0;
      missCnt  <= '0;
      stallCyc <= '0;
    end else begin
      if (state == CHECK && bus.cache_hit && hitCnt != 32'hFFFF_FFFF)
        hitCnt <= hitCnt + 32'd1;
      if (state == CHECK && !bus.cache_hit && missCnt != 32'hFFFF_FFFF)
        missCnt <= missCnt + 32'd1;
      if (stall && stallCyc != 32'hFFFF_FFFF)
        stallCyc <= stallCyc + 32'd1;
    end
  end

  assign bus.hit_cnt      = hitCnt;
  assign bus.miss_cnt     = missCnt;
  assign bus.stall_cycles = stallCyc;
`else
  assign bus.hit_cnt      = 32'h0;
  assign bus.miss_cnt     = 32'h0;
  assign bus.stall_cycles = 32'h0;
`endif
endmodule
